// File: rtl/tree_sum_accumulator.sv
// Frame accumulator for the adder-tree sum stream.
// Adds 2**N_LOG2 accepted samples into one frame total and presents the total
// and its truncated mean through a one-deep valid/ready output register.
// Accumulation of the next frame continues while a result waits. The only
// stall is when the final sample of a frame would overwrite an untaken result.
module tree_sum_accumulator #(
  parameter int N_LOG2 = 3,
  parameter int WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic                    sync_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH+N_LOG2-1:0] out_sum,
  output logic [WIDTH-1:0]        out_avg,
  output logic [7:0]              frame_cnt
);

  localparam int SW = WIDTH + N_LOG2;

  // The frame total cannot overflow: 2**N_LOG2 samples of WIDTH bits fit in SW bits.
  logic [SW-1:0]     acc;
  logic [N_LOG2-1:0] cnt;

  logic          is_last;
  logic          accept;
  logic          complete;
  logic          handoff;
  logic [SW-1:0] frame_total;

  assign is_last     = (cnt == {N_LOG2{1'b1}});
  assign frame_total = acc + SW'(in_data);

  // in_ready depends only on cnt, out_valid, out_ready and sync_clr, never on in_valid.
  assign in_ready = !sync_clr && !(is_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign complete = accept && is_last;
  assign handoff  = out_valid && out_ready;

  // Accumulator and sample counter: cleared by sync_clr, advanced on each accepted sample.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values and the block order does not matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (sync_clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (is_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= frame_total;
        cnt <= cnt + N_LOG2'(1);
      end
    end
  end

  // Output register: loads on completion, drops on handoff, otherwise holds.
  // A completion that coincides with a handoff reloads and keeps out_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_avg   <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_sum   <= frame_total;
      out_avg   <= frame_total[SW-1:N_LOG2];
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  // Count of results taken by the consumer. It wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (handoff) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Self-checking bench for tree_sum_accumulator (N_LOG2=3, WIDTH=16).
// Inputs change 1 ns after the rising edge. A monitor on the falling edge
// predicts in_ready, pushes expected frame totals when a frame's final sample
// is accepted, and pops/compares them when the consumer takes a result.
module tb_tree_sum_accumulator;

  localparam int N     = 3;
  localparam int W     = 16;
  localparam int SW    = W + N;
  localparam int LAST  = (1 << N) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          sync_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_sum;
  logic [W-1:0]  out_avg;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;

  // Scoreboard and reference model state
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] m_acc = '0;
  int            m_cnt = 0;
  logic [7:0]    m_fc  = '0;
  logic          prev_hold = 1'b0;
  logic [SW-1:0] prev_sum  = '0;

  tree_sum_accumulator #(.N_LOG2(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .sync_clr  (sync_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: model the handshakes that the next rising edge will perform.
  always @(negedge clk or posedge rst) begin
    logic          exp_ready;
    logic [SW-1:0] e;
    if (rst) begin
      exp_q.delete();
      m_acc     = '0;
      m_cnt     = 0;
      m_fc      = '0;
      prev_hold = 1'b0;
    end else begin
      exp_ready = !sync_clr && !(m_cnt == LAST && out_valid && !out_ready);
      n_checks++;
      if (in_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL mon_in_ready t=%0t got=%b exp=%b", $time, in_ready, exp_ready);
      end
      n_checks++;
      if (frame_cnt !== m_fc) begin
        n_fail++;
        $display("FAIL mon_frame_cnt t=%0t got=%0d exp=%0d", $time, frame_cnt, m_fc);
      end
      if (prev_hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
          n_fail++;
          $display("FAIL mon_hold t=%0t got=%b/%0d exp=1/%0d", $time, out_valid, out_sum, prev_sum);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL mon_pop_empty t=%0t got_sum=%0d exp=no_result", $time, out_sum);
        end else begin
          e = exp_q.pop_front();
          if (out_sum !== e || out_avg !== e[SW-1:N]) begin
            n_fail++;
            $display("FAIL mon_result t=%0t got=%0d/%0d exp=%0d/%0d",
                     $time, out_sum, out_avg, e, e[SW-1:N]);
          end
        end
        m_fc = m_fc + 8'd1;
        n_popped++;
      end
      if (sync_clr) begin
        m_acc = '0;
        m_cnt = 0;
      end else if (in_valid && exp_ready) begin
        m_acc = m_acc + SW'(in_data);
        if (m_cnt == LAST) begin
          exp_q.push_back(m_acc);
          m_acc = '0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Present one sample, then step past the next edge.
  task automatic feed(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== '0 ||
        out_avg !== '0 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_values got rdy=%b v=%b sum=%0d avg=%0d fc=%0d exp 1/0/0/0/0",
               in_ready, out_valid, out_sum, out_avg, frame_cnt);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) feed(W'(i));
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 19'd36 || out_avg !== 16'd4 || frame_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL basic_result got v=%b sum=%0d avg=%0d fc=%0d exp 1/36/4/0",
               out_valid, out_sum, out_avg, frame_cnt);
    end
    idle(1);
    n_checks++;
    if (frame_cnt !== 8'd1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_handoff got fc=%0d v=%b exp 1/0", frame_cnt, out_valid);
    end
  endtask

  task automatic test_max;
    out_ready = 1'b1;
    repeat (8) feed(16'hFFFF);
    n_checks++;
    if (out_sum !== 19'h7FFF8 || out_avg !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL max_result got sum=%h avg=%h exp 7fff8/ffff", out_sum, out_avg);
    end
    idle(1);
  endtask

  task automatic test_backpressure;
    logic [7:0] fc0;
    fc0 = frame_cnt;
    out_ready = 1'b0;
    repeat (8) feed(16'd3);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 19'd24) begin
      n_fail++;
      $display("FAIL bp_frame_a got v=%b sum=%0d exp 1/24", out_valid, out_sum);
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd5;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_accept_b%0d got rdy=%b exp 1", i, in_ready);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = 16'd5;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_sum !== 19'd24) begin
      n_fail++;
      $display("FAIL bp_stall got rdy=%b sum=%0d exp 0/24", in_ready, out_sum);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 19'd24) begin
      n_fail++;
      $display("FAIL bp_hold got v=%b sum=%0d exp 1/24", out_valid, out_sum);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release got rdy=%b exp 1", in_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 19'd40 || out_avg !== 16'd5 || frame_cnt !== fc0 + 8'd1) begin
      n_fail++;
      $display("FAIL bp_frame_b got v=%b sum=%0d avg=%0d fc=%0d exp 1/40/5/%0d",
               out_valid, out_sum, out_avg, frame_cnt, fc0 + 8'd1);
    end
    idle(1);
    n_checks++;
    if (out_valid !== 1'b0 || frame_cnt !== fc0 + 8'd2) begin
      n_fail++;
      $display("FAIL bp_final got v=%b fc=%0d exp 0/%0d", out_valid, frame_cnt, fc0 + 8'd2);
    end
  endtask

  task automatic test_sync_clr;
    out_ready = 1'b1;
    repeat (3) feed(16'd100);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'd7;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready got rdy=%b exp 0", in_ready);
    end
    @(posedge clk); #1;
    sync_clr = 1'b0;
    repeat (8) feed(16'd2);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 19'd16 || out_avg !== 16'd2) begin
      n_fail++;
      $display("FAIL clr_result got v=%b sum=%0d avg=%0d exp 1/16/2", out_valid, out_sum, out_avg);
    end
    idle(1);
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    repeat (8) feed(16'd1);
    repeat (4) feed(16'd1);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_avg !== '0 ||
        frame_cnt !== 8'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_clear got v=%b sum=%0d avg=%0d fc=%0d rdy=%b exp 0/0/0/0/1",
               out_valid, out_sum, out_avg, frame_cnt, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) feed(16'd1);
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 19'd8 || out_avg !== 16'd1) begin
      n_fail++;
      $display("FAIL areset_after got v=%b sum=%0d avg=%0d exp 1/8/1", out_valid, out_sum, out_avg);
    end
    idle(1);
  endtask

  task automatic test_random;
    int target;
    target = n_popped + 1000;
    for (int c = 0; c < 40000 && n_popped < target; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_popped < target) begin
      n_fail++;
      $display("FAIL rand_timeout got frames=%0d exp %0d", n_popped, target);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain got pending=%0d v=%b exp 0/0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_backpressure();
    test_sync_clr();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
